// File: rtl/des_round_engine.sv
// des_round_engine: iterative single-DES core, IP -> 16 Feistel rounds (one per clock) -> FP.
// Round keys come from an external key generator; decrypt walks them in reverse.
module des_round_engine (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic        decrypt,
   input  logic [0:63] data_in,
   input  logic [0:47] roundkey_1,  roundkey_2,  roundkey_3,  roundkey_4,
   input  logic [0:47] roundkey_5,  roundkey_6,  roundkey_7,  roundkey_8,
   input  logic [0:47] roundkey_9,  roundkey_10, roundkey_11, roundkey_12,
   input  logic [0:47] roundkey_13, roundkey_14, roundkey_15, roundkey_16,
   output logic [0:63] data_out,
   output logic        busy,
   output logic        done
);
   localparam int IP_T [0:63] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int FP_T [0:63] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int E_T [0:47] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int P_T [0:31] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
       2, 8, 24, 14, 32, 27,  3,  9, 19, 13, 30, 6, 22, 11,  4, 25};
   localparam int SBOX [0:7][0:63] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,  0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
         4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,  15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,  3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
         0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,  13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,  13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,  1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,  13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,  3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,  14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
         4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,  11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,  10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
         9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,  13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
         1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,  1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
         7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   function automatic logic [0:63] ip(input logic [0:63] x);
      logic [0:63] y;
      for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
      return y;
   endfunction

   function automatic logic [0:63] fp(input logic [0:63] x);
      logic [0:63] y;
      for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
      return y;
   endfunction

   function automatic logic [0:47] e_exp(input logic [0:31] x);
      logic [0:47] y;
      for (int i = 0; i < 48; i++) y[i] = x[E_T[i] - 1];
      return y;
   endfunction

   function automatic logic [0:31] p_perm(input logic [0:31] x);
      logic [0:31] y;
      for (int i = 0; i < 32; i++) y[i] = x[P_T[i] - 1];
      return y;
   endfunction

   // Row is the outer bit pair of each 6-bit group, column the inner four bits.
   function automatic logic [0:31] sbox(input logic [0:47] x);
      logic [0:31] y;
      logic [5:0]  s;
      for (int b = 0; b < 8; b++) begin
         s = x[6*b +: 6];
         y[4*b +: 4] = 4'(SBOX[b][{s[5], s[0], s[4:1]}]);
      end
      return y;
   endfunction

   typedef enum logic {IDLE, ROUND} state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        dec_q, busy_q, done_q;
   logic [0:31] l_q, r_q, r_d;
   logic [0:63] dout_q;
   logic [0:47] k;
   logic [0:47] rk [0:15];

   assign rk = '{roundkey_1, roundkey_2, roundkey_3, roundkey_4, roundkey_5, roundkey_6,
                 roundkey_7, roundkey_8, roundkey_9, roundkey_10, roundkey_11, roundkey_12,
                 roundkey_13, roundkey_14, roundkey_15, roundkey_16};
   assign k   = rk[dec_q ? 4'd15 - cnt_q : cnt_q];
   assign r_d = l_q ^ p_perm(sbox(e_exp(r_q) ^ k));

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         l_q     <= '0;
         r_q     <= '0;
         dout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (start) begin
               dec_q      <= decrypt;
               {l_q, r_q} <= ip(data_in);
               cnt_q      <= '0;
               busy_q     <= 1'b1;
               state_q    <= ROUND;
            end
         end else begin
            l_q   <= r_q;
            r_q   <= r_d;
            cnt_q <= cnt_q + 4'd1;
            // Last round: the output swap means preoutput is {R16, L16} = {r_d, r_q}.
            if (cnt_q == 4'd15) begin
               dout_q  <= fp({r_d, r_q});
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         end
      end
   end

   assign data_out = dout_q;
   assign busy     = busy_q;
   assign done     = done_q;
endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: known-answer and randomized checks of des_round_engine against
// a standalone DES model (key schedule included) built on plain integer arithmetic.
module tb_des_round_engine;
   logic        clk = 1'b0;
   logic        n_rst, start, decrypt;
   logic [63:0] data_in;
   logic [63:0] data_out;
   logic        busy, done;
   logic [47:0] rk [16];
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   des_round_engine dut (
      .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .data_in(data_in),
      .roundkey_1(rk[0]),   .roundkey_2(rk[1]),   .roundkey_3(rk[2]),   .roundkey_4(rk[3]),
      .roundkey_5(rk[4]),   .roundkey_6(rk[5]),   .roundkey_7(rk[6]),   .roundkey_8(rk[7]),
      .roundkey_9(rk[8]),   .roundkey_10(rk[9]),  .roundkey_11(rk[10]), .roundkey_12(rk[11]),
      .roundkey_13(rk[12]), .roundkey_14(rk[13]), .roundkey_15(rk[14]), .roundkey_16(rk[15]),
      .data_out(data_out), .busy(busy), .done(done));

   int ip_q[$] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                   57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   int fp_q[$] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                   36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   int e_q[$]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,
                   22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   int p_q[$]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   int pc1_q[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   int pc2_q[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   int sb [8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // DES bit n (1 = MSB) of a win-bit value sits at x[win-n]; output width is the table length.
   function automatic logic [63:0] perm(input logic [63:0] x, input int win, input int t[$]);
      logic [63:0] y = '0;
      for (int i = 0; i < t.size(); i++) y[t.size() - 1 - i] = x[win - t[i]];
      return y;
   endfunction

   function automatic logic [31:0] sbox(input logic [47:0] v);
      logic [31:0] o = '0;
      int six;
      for (int b = 0; b < 8; b++) begin
         six = int'((v >> (42 - 6 * b)) & 48'h3f);
         o = (o << 4) | 32'(sb[b][(six & 32) | ((six & 1) << 4) | ((six >> 1) & 15)]);
      end
      return o;
   endfunction

   function automatic logic [47:0] rkey(input logic [63:0] key, input int n);
      logic [63:0] t;
      logic [27:0] c, d;
      t = perm(key, 64, pc1_q);
      c = t[55:28];
      d = t[27:0];
      for (int i = 0; i <= n; i++)
         for (int s = 0; s < shifts[i]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
      t = perm({8'h0, c, d}, 56, pc2_q);
      return t[47:0];
   endfunction

   function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk, input logic dec);
      logic [63:0] x;
      logic [31:0] l, r, t;
      x = perm(blk, 64, ip_q);
      l = x[63:32];
      r = x[31:0];
      for (int i = 0; i < 16; i++) begin
         x = perm({32'h0, r}, 32, e_q);
         x = perm({32'h0, sbox(x[47:0] ^ rkey(key, dec ? 15 - i : i))}, 32, p_q);
         t = r;
         r = l ^ x[31:0];
         l = t;
      end
      return perm({r, l}, 64, fp_q);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_key(input logic [63:0] key);
      for (int i = 0; i < 16; i++) rk[i] = rkey(key, i);
   endtask

   task automatic run(input logic [63:0] din, input logic dec, input logic [63:0] exp, input string nm);
      int lat = 0, bc = 0;
      data_in = din;
      decrypt = dec;
      start   = 1'b1;
      tick;
      start   = 1'b0;
      data_in = {$urandom, $urandom};
      decrypt = ~dec;
      while (!done && lat < 40) begin
         bc += int'(busy);
         tick;
         lat++;
      end
      chk({nm, " latency"}, lat, 16);
      chk({nm, " busy cycles"}, bc, 16);
      chk({nm, " busy at done"}, busy, 0);
      chk({nm, " data_out"}, data_out, exp);
      tick;
      chk({nm, " done width"}, done, 0);
   endtask

   typedef struct {
      logic [63:0] key, din;
      logic        dec;
      logic [63:0] exp;
   } vec_t;

   initial begin
      vec_t        tbl[$];
      logic [63:0] k, a, res;
      logic [63:0] din_h [51];
      logic        dec_h [51];
      int          nd;
      tbl.push_back('{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405});
      tbl.push_back('{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF});
      tbl.push_back('{64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7});
      tbl.push_back('{64'h0, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0});
      for (int i = 0; i < 6; i++) begin
         k = {$urandom, $urandom};
         a = {$urandom, $urandom};
         tbl.push_back('{k, a, 1'(i % 2), des(k, a, 1'(i % 2))});
      end

      n_rst = 1'b0; start = 1'b0; decrypt = 1'b0; data_in = '0;
      set_key(64'h0);
      tick;
      tick;
      n_rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick;
         chk("idle data_out", data_out, 0);
         chk("idle busy/done", {busy, done}, 0);
      end

      foreach (tbl[i]) begin
         set_key(tbl[i].key);
         run(tbl[i].din, tbl[i].dec, tbl[i].exp, $sformatf("vec%0d", i));
      end

      k = {$urandom, $urandom};
      a = {$urandom, $urandom};
      set_key(k);
      data_in = a; decrypt = 1'b0; start = 1'b1;
      tick;
      nd = 0; res = '0;
      for (int c = 1; c <= 40; c++) begin
         start   = (c == 5 || c == 10);
         data_in = {$urandom, $urandom};
         decrypt = 1'($urandom);
         tick;
         if (done) begin
            nd++;
            res = data_out;
         end
      end
      chk("ignored start done count", nd, 1);
      chk("ignored start data_out", res, des(k, a, 1'b0));

      nd = 0;
      start = 1'b1;
      for (int e = 0; e < 51; e++) begin
         din_h[e] = {$urandom, $urandom};
         dec_h[e] = 1'($urandom);
         data_in = din_h[e];
         decrypt = dec_h[e];
         tick;
         if (done) begin
            if (nd < 3) begin
               chk("b2b done edge", e, 16 + 17 * nd);
               chk("b2b data_out", data_out, des(k, din_h[17 * nd], dec_h[17 * nd]));
            end
            nd++;
         end
      end
      start = 1'b0;
      chk("b2b done count", nd, 3);
      tick;
      tick;

      a = {$urandom, $urandom};
      data_in = a; decrypt = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (7) tick;
      n_rst = 1'b0;
      tick;
      chk("abort data_out", data_out, 0);
      chk("abort busy/done", {busy, done}, 0);
      n_rst = 1'b1;
      nd = 0;
      repeat (25) begin
         tick;
         nd += int'(done);
      end
      chk("abort no done", nd, 0);
      run(a, 1'b1, des(k, a, 1'b1), "post reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
